match_event_logger: RTL and testbench

- Downstream consumer of the 1011 sequence detector's `match` output.
- Maintains a running bit-position index of the qualified serial stream.
- Records the index of every match into a small first-word-fall-through FIFO, readable by a host through a valid/ready handshake.
- Keeps a saturating match count and a sticky overflow flag, so software can read detection events without losing position information.

---
 rtl/match_event_logger.sv | 101 ++++++++++
 tb/tb_match_event_logger.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/match_event_logger.sv
// Logs the stream bit index of every qualified 1011-detector match into a small
// first-word-fall-through FIFO, with a saturating match counter and a sticky overflow flag.
module match_event_logger #(
    parameter int IDX_W = 16,
    parameter int CNT_W = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       match,
    input  logic                       clear,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [IDX_W-1:0]           evt_idx,
    output logic [CNT_W-1:0]           match_count,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [IDX_W-1:0] r_bit_idx;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_overflow;
    logic [IDX_W-1:0] r_mem [DEPTH];

    logic             w_push_req;
    logic             w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [LVL_W-1:0] w_level_next;

    assign w_push_req = en & match;
    assign w_valid    = (r_level != '0);
    assign w_full     = (r_level == LVL_W'(DEPTH));
    assign w_pop      = w_valid & evt_ready;
    // A full FIFO still accepts a push when the head is being popped in the same cycle.
    assign w_push     = w_push_req & (~w_full | w_pop);

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + LVL_W'(1);
        end else if (w_pop && !w_push) begin
            w_level_next = r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_idx  <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_bit_idx  <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (en) begin
                r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
            if (w_push_req && (r_count != '1)) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_push_req && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= w_level_next;
        end
    end

    // Storage carries no reset; stale contents are hidden because the output is gated by valid.
    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem[r_wr_ptr] <= r_bit_idx;
        end
    end

    assign evt_valid   = w_valid;
    assign evt_idx     = w_valid ? r_mem[r_rd_ptr] : '0;
    assign match_count = r_count;
    assign fifo_level  = r_level;
    assign overflow    = r_overflow;
endmodule

// File: tb/tb_match_event_logger.sv
// Directed self-checking bench for match_event_logger (DEPTH=8, IDX_W=16 plus an IDX_W=4 copy for wrap).
module tb_match_event_logger;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        match;
    logic        clear;
    logic        evt_ready;
    logic        evt_valid;
    logic [15:0] evt_idx;
    logic [15:0] match_count;
    logic [3:0]  fifo_level;
    logic        overflow;

    logic        evt_valid4;
    logic [3:0]  evt_idx4;
    logic [15:0] match_count4;
    logic [3:0]  fifo_level4;
    logic        overflow4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    match_event_logger #(.IDX_W(16), .CNT_W(16), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .match(match), .clear(clear),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_idx(evt_idx),
        .match_count(match_count), .fifo_level(fifo_level), .overflow(overflow)
    );

    match_event_logger #(.IDX_W(4), .CNT_W(16), .DEPTH(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .match(match), .clear(clear),
        .evt_valid(evt_valid4), .evt_ready(evt_ready), .evt_idx(evt_idx4),
        .match_count(match_count4), .fifo_level(fifo_level4), .overflow(overflow4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Apply inputs for one clock; returns 1 time unit after the rising edge.
    task automatic step(input logic e, input logic m, input logic r, input logic c);
        en = e; match = m; evt_ready = r; clear = c;
        @(posedge clk);
        #1;
        en = 1'b0; match = 1'b0; evt_ready = 1'b0; clear = 1'b0;
    endtask

    logic [6:0] pattern;

    initial begin
        rst_n = 1'b0; en = 1'b0; match = 1'b0; clear = 1'b0; evt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_count", 32'(match_count), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        check("rst_idx",   32'(evt_idx), 32'd0);
        rst_n = 1'b1;

        // Stream 1,0,1,1,0,1,1: detector matches at idx 3 and 6.
        pattern = 7'b1001000;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, pattern[i], 1'b0, 1'b0);
            if (i == 3) check("latency_valid", 32'(evt_valid), 32'd1);
        end
        check("t1_level", 32'(fifo_level), 32'd2);
        check("t1_count", 32'(match_count), 32'd2);
        check("t1_idx0",  32'(evt_idx), 32'd3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t1_idx1",  32'(evt_idx), 32'd6);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t1_empty", 32'(evt_valid), 32'd0);
        check("t1_lvl0",  32'(fifo_level), 32'd0);

        // match with en=0 is ignored; bit_idx stays at 7.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t2_count", 32'(match_count), 32'd2);
        check("t2_level", 32'(fifo_level), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0);   // push into empty FIFO with ready high: no bypass
        check("t2_idx",   32'(evt_idx), 32'd7);
        check("t2_lvl",   32'(fifo_level), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t2_drain", 32'(fifo_level), 32'd0);

        // Overflow: 10 matches into an 8-deep FIFO.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t3_level", 32'(fifo_level), 32'd8);
        check("t3_count", 32'(match_count), 32'd10);
        check("t3_ovf",   32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_drain%0d", i), 32'(evt_idx), 32'(i));
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        check("t3_empty", 32'(evt_valid), 32'd0);
        check("t3_ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO with simultaneous push and pop.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("t4_level", 32'(fifo_level), 32'd8);
        check("t4_ovf",   32'(overflow), 32'd0);
        check("t4_count", 32'(match_count), 32'd9);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("t4_drain%0d", i), 32'(evt_idx), 32'(i));
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        check("t4_empty", 32'(evt_valid), 32'd0);

        // Index wrap on the IDX_W=4 instance: match on the 17th en cycle (idx 16).
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b1, (i == 16) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        check("t5_idx4",   32'(evt_idx4), 32'd0);
        check("t5_valid4", 32'(evt_valid4), 32'd1);
        check("t5_idx16",  32'(evt_idx), 32'd16);

        // Clear together with push_req and pop.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t6_pre_lvl", 32'(fifo_level), 32'd3);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("t6_level", 32'(fifo_level), 32'd0);
        check("t6_count", 32'(match_count), 32'd0);
        check("t6_valid", 32'(evt_valid), 32'd0);
        check("t6_ovf",   32'(overflow), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t6_idx",   32'(evt_idx), 32'd0);
        check("t6_cnt1",  32'(match_count), 32'd1);

        // Async reset mid-cycle takes effect before the next clock edge.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t7_pre_lvl", 32'(fifo_level), 32'd2);
        #3 rst_n = 1'b0;
        #1;
        check("t7_level", 32'(fifo_level), 32'd0);
        check("t7_count", 32'(match_count), 32'd0);
        check("t7_valid", 32'(evt_valid), 32'd0);
        check("t7_idx",   32'(evt_idx), 32'd0);
        #1 rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t7_idx_after", 32'(evt_idx), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
